// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus controller: FSM encoding, default slot map,
// error data and the saturating error-counter helper.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Slot 3 = 0xF..., slot 2 = 0xE..., slot 1 = 0xC..., slot 0 = 0x0...
  localparam logic [15:0] SLOT_TAG_DFLT = 16'hFEC0;
  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) begin
      return v + 8'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side and peripheral-side signal bundle of the MIO bus controller.
// The controller uses the slave modport; the CPU/peripheral environment uses master.
interface mio_bus_ctrl_if #(
  parameter int N_SLOTS = 4,
  parameter int DW      = 32,
  parameter int AW      = 10
);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [DW-1:0]         cpu_wdata;
  logic                  cpu_ready;
  logic [DW-1:0]         cpu_rdata;
  logic                  cpu_err;

  logic [N_SLOTS-1:0]    slv_sel;
  logic                  slv_we;
  logic [AW-1:0]         slv_addr;
  logic [DW-1:0]         slv_wdata;
  logic [N_SLOTS*DW-1:0] slv_rdata;
  logic [N_SLOTS-1:0]    slv_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_ready, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    output cpu_ready, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

endinterface

// File: rtl/mio_addr_decode.sv
// Combinational slot decoder: compares the address tag against every slot tag and
// keeps only the lowest matching index.
module mio_addr_decode #(
  parameter int                     N_SLOTS  = 4,
  parameter int                     IW       = 2,
  parameter logic [N_SLOTS*4-1:0]   SLOT_TAG = 16'hFEC0
) (
  input  logic [3:0]         i_tag,
  output logic [N_SLOTS-1:0] o_onehot,
  output logic               o_hit,
  output logic [IW-1:0]      o_idx
);

  logic [N_SLOTS-1:0] w_match;

  // Raw per-slot tag comparison
  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_match[i] = (SLOT_TAG[4*i +: 4] == i_tag);
    end
  end

  // Isolate the lowest set bit and encode it
  always_comb begin
    o_onehot = w_match & (~w_match + N_SLOTS'(1));
    o_hit    = |w_match;
    o_idx    = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      o_idx = o_idx | (o_onehot[i] ? IW'(i) : IW'(0));
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory-mapped I/O bus controller: registered request/ack handshake between the
// CPU and N peripheral slots with wait states, timeout and unmapped-address errors.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int                   N_SLOTS  = 4,
  parameter int                   DW       = 32,
  parameter int                   AW       = 10,
  parameter logic [N_SLOTS*4-1:0] SLOT_TAG = SLOT_TAG_DFLT,
  parameter int                   TIMEOUT  = 15,
  parameter logic [DW-1:0]        ERR_DATA = ERR_DATA_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  mio_bus_ctrl_if.slave  bus,
  output logic [7:0]     err_cnt
);

  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic                r_we;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [IW-1:0]       r_idx;
  logic [WW-1:0]       r_wait;
  logic                r_ready;
  logic                r_cpu_err;
  logic [DW-1:0]       r_rdata;
  logic [N_SLOTS-1:0]  r_sel;
  logic                r_slv_we;
  logic [7:0]          r_err_cnt;

  logic [N_SLOTS-1:0]  w_onehot;
  logic                w_hit;
  logic [IW-1:0]       w_idx;
  logic                w_ack;
  logic [DW-1:0]       w_rdata;
  logic                w_unused_addr;

  mio_addr_decode #(
    .N_SLOTS  (N_SLOTS),
    .IW       (IW),
    .SLOT_TAG (SLOT_TAG)
  ) u_decode (
    .i_tag    (bus.cpu_addr[31:28]),
    .o_onehot (w_onehot),
    .o_hit    (w_hit),
    .o_idx    (w_idx)
  );

  // Only the latched slot's ack and data are ever looked at
  assign w_ack   = bus.slv_ack[r_idx];
  assign w_rdata = bus.slv_rdata[r_idx*DW +: DW];

  assign w_unused_addr = ^{bus.cpu_addr[27:AW+2], bus.cpu_addr[1:0]};

  // Request FSM, wait counter, completion registers and error counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_ready   <= 1'b0;
      r_cpu_err <= 1'b0;
      r_rdata   <= '0;
      r_sel     <= '0;
      r_slv_we  <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_ready   <= 1'b0;
      r_cpu_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wait <= '0;
          if (bus.cpu_req) begin
            r_we    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr[AW+1:2];
            r_wdata <= bus.cpu_wdata;
            if (w_hit) begin
              r_idx    <= w_idx;
              r_sel    <= w_onehot;
              r_slv_we <= bus.cpu_we;
              r_state  <= ST_ACCESS;
            end else begin
              r_ready   <= 1'b1;
              r_cpu_err <= 1'b1;
              r_rdata   <= ERR_DATA;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_ACCESS: begin
          if (w_ack) begin
            r_sel    <= '0;
            r_slv_we <= 1'b0;
            r_ready  <= 1'b1;
            r_rdata  <= r_we ? '0 : w_rdata;
            r_state  <= ST_DONE;
          end else if (r_wait == WW'(TIMEOUT)) begin
            r_sel     <= '0;
            r_slv_we  <= 1'b0;
            r_ready   <= 1'b1;
            r_cpu_err <= 1'b1;
            r_rdata   <= ERR_DATA;
            r_state   <= ST_DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_DONE: begin
          r_err_cnt <= sat_inc8(r_err_cnt, r_cpu_err);
          r_state   <= ST_IDLE;
        end
        default: begin
          r_sel    <= '0;
          r_slv_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ready = r_ready;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.cpu_rdata = r_rdata;
  assign bus.slv_sel   = r_sel;
  assign bus.slv_we    = r_slv_we;
  assign bus.slv_addr  = r_addr;
  assign bus.slv_wdata = r_wdata;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl: stimulus pushes expected completions, a
// negedge monitor pops and checks them together with the slave-side bus.
module tb_mio_bus_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] err_cnt;

  mio_bus_ctrl_if #(.N_SLOTS(4), .DW(32), .AW(10)) bus ();

  mio_bus_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ready_cnt = 0;
  int          sel_cycles = 0;
  int          we_cycles  = 0;
  int          acc_cnt    = 0;
  int          ack_delay[4];
  logic [3:0]  stray_ack;
  logic [3:0]  exp_sel;
  logic [9:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_we;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Peripheral model: selected slot acks after its programmed number of waits
  always @(negedge clk) begin
    logic [3:0] ack_v;
    ack_v = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      ack_v[s] = bus.slv_sel[s] && (acc_cnt == ack_delay[s]);
    end
    if (bus.slv_sel != 4'b0000) acc_cnt++;
    else acc_cnt = 0;
    bus.slv_ack = ack_v | stray_ack;
  end

  // Monitor: completions against the scoreboard, slave bus against the current access
  always @(negedge clk) begin
    exp_t e;
    if (bus.cpu_ready === 1'b1) begin
      ready_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: cpu_ready=1 at edge %0d, required no completion", cyc + 1);
      end else begin
        e = sb.pop_front();
        check("ready_edge", cyc + 1, e.cyc);
        check("cpu_rdata", bus.cpu_rdata, e.rdata);
        check("cpu_err", {31'd0, bus.cpu_err}, {31'd0, e.err});
      end
    end
    if (bus.slv_sel != 4'b0000) begin
      sel_cycles++;
      if (bus.slv_we === 1'b1) we_cycles++;
      check("slv_sel", {28'd0, bus.slv_sel}, {28'd0, exp_sel});
      check("slv_addr", {22'd0, bus.slv_addr}, {22'd0, exp_addr});
      check("slv_wdata", bus.slv_wdata, exp_wdata);
      check("slv_we", {31'd0, bus.slv_we}, {31'd0, exp_we});
    end else if (bus.slv_we !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL slv_we_idle: slv_we=%b with no slot selected, required 0", bus.slv_we);
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] sel, input int lat,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    exp_sel   = sel;
    exp_addr  = addr[11:2];
    exp_wdata = wd;
    exp_we    = we;
    e.cyc   = cyc + 1 + lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL completion_wait: %0d completions pending after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int   base;
    exp_t e;

    rst            = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 32'd0;
    bus.cpu_wdata  = 32'd0;
    bus.slv_rdata  = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0BAD_0000};
    bus.slv_ack    = 4'b0000;
    stray_ack      = 4'b0000;
    ack_delay[0]   = 255;
    ack_delay[1]   = 0;
    ack_delay[2]   = 0;
    ack_delay[3]   = 3;
    exp_sel        = 4'b0000;
    exp_addr       = 10'd0;
    exp_wdata      = 32'd0;
    exp_we         = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
    check("rst_err", {31'd0, bus.cpu_err}, 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_sel", {28'd0, bus.slv_sel}, 32'd0);
    check("rst_addr", {22'd0, bus.slv_addr}, 32'd0);
    check("rst_wdata", bus.slv_wdata, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait read of slot 1, word address 1
    issue(1'b0, 32'hC000_0004, 32'h0, 4'b0010, 2, 32'h1234_5678, 1'b0);
    wait_done(20);
    check("rdata_held", bus.cpu_rdata, 32'h1234_5678);
    check("ready_pulse_once", {31'd0, bus.cpu_ready}, 32'd0);

    // Write to slot 3 with three wait states; write completes with zero data
    we_cycles = 0;
    issue(1'b1, 32'hF000_0000, 32'h0000_00A5, 4'b1000, 5, 32'h0, 1'b0);
    wait_done(20);
    check("write_we_cycles", we_cycles, 32'd4);
    check("err_cnt_after_ok", {24'd0, err_cnt}, 32'd0);

    // Unmapped tag 0x5
    sel_cycles = 0;
    issue(1'b0, 32'h5000_0000, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1);
    wait_done(20);
    check("unmapped_no_sel", sel_cycles, 32'd0);
    check("err_cnt_unmapped", {24'd0, err_cnt}, 32'd1);

    // Slot 0 never acks: timeout after 15 waits
    sel_cycles = 0;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'b0001, 17, 32'hDEAD_BEEF, 1'b1);
    wait_done(40);
    check("timeout_sel_cycles", sel_cycles, 32'd16);
    check("err_cnt_timeout", {24'd0, err_cnt}, 32'd2);

    // Saturation of the error counter
    for (int i = 0; i < 299; i++) begin
      issue(1'b0, 32'h0000_0010, 32'h0, 4'b0001, 17, 32'hDEAD_BEEF, 1'b1);
      wait_done(40);
    end
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset in the second ACCESS cycle abandons the access
    ack_delay[1] = 255;
    ready_cnt = 0;
    issue(1'b0, 32'hC000_0008, 32'h0, 4'b0010, 2, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    check("midrst_sel", {28'd0, bus.slv_sel}, 32'd0);
    check("midrst_ready", {31'd0, bus.cpu_ready}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("midrst_addr", {22'd0, bus.slv_addr}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_pulse", ready_cnt, 32'd0);
    ack_delay[1] = 0;
    issue(1'b0, 32'hC000_0008, 32'h0, 4'b0010, 2, 32'h1234_5678, 1'b0);
    wait_done(20);

    // Stray ack from slot 2 while slot 1 waits two cycles
    stray_ack    = 4'b0100;
    ack_delay[1] = 2;
    issue(1'b0, 32'hC000_000C, 32'h0, 4'b0010, 4, 32'h1234_5678, 1'b0);
    wait_done(20);

    // Held request: one zero-wait completion every 3 cycles
    ack_delay[1] = 0;
    ready_cnt = 0;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'hC000_000C;
    bus.cpu_wdata = 32'h0;
    exp_sel   = 4'b0010;
    exp_addr  = 10'd3;
    exp_wdata = 32'h0;
    exp_we    = 1'b0;
    base = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      e.cyc   = base + 3*j + 2;
      e.rdata = 32'h1234_5678;
      e.err   = 1'b0;
      sb.push_back(e);
    end
    repeat (7) @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_done(20);
    repeat (4) @(negedge clk);
    check("held_req_completions", ready_cnt, 32'd3);
    stray_ack = 4'b0000;

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
